// File: rtl/iir_mac_accum_p3_if.sv
// Beat/result bundle between the IIR term sequencer and the pipelined MAC.
// The master drives framed (a, b) beats; the slave returns saturated sums and status.
interface iir_mac_accum_p3_if #(
  parameter int DataWidth  = 16,
  parameter int CoefWidth  = 16,
  parameter int WordLength = 32
);
  logic                         in_valid;
  logic                         in_first;
  logic                         in_last;
  logic signed [DataWidth-1:0]  a;
  logic signed [CoefWidth-1:0]  b;
  logic signed [WordLength-1:0] y;
  logic                         y_valid;
  logic                         ovf;
  logic                         err;
  logic                         busy;

  modport master (
    output in_valid, in_first, in_last, a, b,
    input  y, y_valid, ovf, err, busy
  );

  modport slave (
    input  in_valid, in_first, in_last, a, b,
    output y, y_valid, ovf, err, busy
  );
endinterface

// File: rtl/iir_mac_accum_p3.sv
// Pipelined signed multiply-accumulate for one IIR output: registered inputs, product,
// framed accumulation with a term-count guard, then saturation to WordLength.
module iir_mac_accum_p3 #(
  parameter int DataWidth  = 16,
  parameter int CoefWidth  = 16,
  parameter int GuardBits  = 4,
  parameter int WordLength = 32,
  parameter int MaxTerms   = 8
) (
  input logic              CLK,
  input logic              RESET,
  input logic              CE,
  iir_mac_accum_p3_if.slave bus
);
  localparam int ProdW = DataWidth + CoefWidth;
  localparam int AccW  = ProdW + GuardBits;
  localparam int CntW  = $clog2(MaxTerms + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTerms);

  typedef enum logic {IDLE, ACCUM} state_t;

  // Input capture
  logic                        s0_valid, s0_first, s0_last;
  logic signed [DataWidth-1:0] s0_a;
  logic signed [CoefWidth-1:0] s0_b;

  // Product stage
  logic                        s1_valid, s1_first, s1_last;
  logic signed [ProdW-1:0]     s1_p;

  // Accumulate stage
  state_t                      state, state_n;
  logic signed [AccW-1:0]      acc, acc_n, p_ext;
  logic [CntW-1:0]             cnt, cnt_n;
  logic                        s2_valid, s2_emit, s2_err;
  logic                        emit_n, err_n;

  // Saturation stage
  logic [WordLength-1:0]       y_n;
  logic                        clamp_n;

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every stage samples
    // the previous cycle's values regardless of statement order.
    if (RESET) begin
      s0_valid <= 1'b0;
      s0_first <= 1'b0;
      s0_last  <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
    end else if (CE) begin
      s0_valid <= bus.in_valid;
      s0_first <= bus.in_first;
      s0_last  <= bus.in_last;
      s0_a     <= bus.a;
      s0_b     <= bus.b;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_p     <= '0;
    end else if (CE) begin
      s1_valid <= s0_valid;
      s1_first <= s0_first;
      s1_last  <= s0_last;
      s1_p     <= s0_a * s0_b;
    end
  end

  assign p_ext = AccW'(s1_p);

  always_comb begin
    // NOTE: defaults first; any branch that skips an assignment keeps the current
    // register value instead of inferring a latch.
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    emit_n  = 1'b0;
    err_n   = 1'b0;
    if (s1_valid) begin
      if (s1_first) begin
        // A first beat always restarts; inside an open sum that is a framing error.
        err_n = (state == ACCUM);
        acc_n = p_ext;
        cnt_n = CntW'(1);
        if (s1_last) begin
          emit_n  = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          state_n = ACCUM;
        end
      end else if (state == IDLE) begin
        err_n = 1'b1;
      end else begin
        acc_n = acc + p_ext;
        if (cnt == MaxCnt) err_n = 1'b1;
        else               cnt_n = cnt + 1'b1;
        if (s1_last) begin
          emit_n  = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      s2_valid <= 1'b0;
      s2_emit  <= 1'b0;
      s2_err   <= 1'b0;
    end else if (CE) begin
      state    <= state_n;
      acc      <= acc_n;
      cnt      <= cnt_n;
      s2_valid <= s1_valid;
      s2_emit  <= emit_n;
      s2_err   <= err_n;
    end
  end

  if (AccW > WordLength) begin : g_clamp
    // In range only when every bit above the output sign bit matches it.
    logic [AccW-WordLength:0] top;
    assign top = acc[AccW-1:WordLength-1];
    always_comb begin
      clamp_n = !((&top) || !(|top));
      if (clamp_n)
        y_n = acc[AccW-1] ? {1'b1, {(WordLength-1){1'b0}}} : {1'b0, {(WordLength-1){1'b1}}};
      else
        y_n = acc[WordLength-1:0];
    end
  end else begin : g_extend
    assign y_n     = WordLength'(acc);
    assign clamp_n = 1'b0;
  end

  // err is delayed alongside the result so a beat's error and emit share a cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus.y       <= '0;
      bus.y_valid <= 1'b0;
      bus.ovf     <= 1'b0;
      bus.err     <= 1'b0;
    end else if (CE) begin
      bus.y_valid <= s2_emit;
      bus.err     <= s2_err;
      if (s2_emit) begin
        bus.y   <= y_n;
        bus.ovf <= clamp_n;
      end
    end
  end

  assign bus.busy = (state == ACCUM) | s0_valid | s1_valid | s2_valid;

endmodule

// File: tb/tb_iir_mac_accum_p3.sv
// Scoreboard bench for iir_mac_accum_p3: a term-list reference model queues expected
// results/errors per accepted beat; a negedge monitor consumes them on CE-enabled cycles.
module tb_iir_mac_accum_p3;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int GB = 4;
  localparam int WL = 32;
  localparam int MT = 8;

  logic clk = 1'b0;
  logic rst;
  logic ce;
  always #5 clk = ~clk;

  iir_mac_accum_p3_if #(.DataWidth(DW), .CoefWidth(CW), .WordLength(WL)) bus();

  iir_mac_accum_p3 #(
    .DataWidth(DW), .CoefWidth(CW), .GuardBits(GB), .WordLength(WL), .MaxTerms(MT)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .CE(ce),
    .bus(bus)
  );

  typedef struct {
    bit            emit;
    logic [WL-1:0] y;
    bit            ovf;
    bit            err;
  } ev_t;

  ev_t    exp_q[$];
  longint terms[$];
  bit     open_sum = 1'b0;
  int     total = 0;
  int     bad = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: a sum is a list of products; the result is their exact sum, clamped.
  function automatic void model_beat(bit f, bit l, logic signed [DW-1:0] a,
                                     logic signed [CW-1:0] b);
    longint p;
    longint s;
    longint hi;
    longint lo;
    ev_t    ev;
    p  = longint'(a) * longint'(b);
    hi = (longint'(1) <<< (WL - 1)) - 1;
    lo = -hi - 1;
    ev.emit = 1'b0;
    ev.err  = 1'b0;
    ev.y    = '0;
    ev.ovf  = 1'b0;
    if (f) begin
      ev.err = open_sum;
      terms.delete();
      terms.push_back(p);
      open_sum = !l;
      ev.emit  = l;
    end else if (!open_sum) begin
      ev.err = 1'b1;
    end else begin
      ev.err = (terms.size() >= MT);
      terms.push_back(p);
      if (l) begin
        ev.emit  = 1'b1;
        open_sum = 1'b0;
      end
    end
    if (ev.emit) begin
      s = 0;
      foreach (terms[i]) s += terms[i];
      if (s > hi) begin
        ev.y = WL'(hi); ev.ovf = 1'b1;
      end else if (s < lo) begin
        ev.y = WL'(lo); ev.ovf = 1'b1;
      end else begin
        ev.y = WL'(s);
      end
    end
    if (ev.emit || ev.err) exp_q.push_back(ev);
  endfunction

  always @(negedge clk) begin : monitor
    ev_t ev;
    if (!rst && ce && (bus.y_valid || bus.err)) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'({bus.y_valid, bus.err}), 64'd0);
      end else begin
        ev = exp_q.pop_front();
        check("sb_y_valid", 64'(bus.y_valid), 64'(ev.emit));
        check("sb_err", 64'(bus.err), 64'(ev.err));
        if (ev.emit) begin
          check("sb_y", 64'(unsigned'(bus.y)), 64'(ev.y));
          check("sb_ovf", 64'(bus.ovf), 64'(ev.ovf));
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(bit v, bit f, bit l, logic signed [DW-1:0] a, logic signed [CW-1:0] b);
    bus.in_valid = v;
    bus.in_first = f;
    bus.in_last  = l;
    bus.a        = a;
    bus.b        = b;
    if (v && ce && !rst) model_beat(f, l, a, b);
    step(1);
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step(1);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    step(3);
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_y"}, 64'(unsigned'(bus.y)), 64'd0);
    check({tag, "_y_valid"}, 64'(bus.y_valid), 64'd0);
    check({tag, "_ovf"}, 64'(bus.ovf), 64'd0);
    check({tag, "_err"}, 64'(bus.err), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : stim
    logic signed [DW-1:0] a4[4];
    rst = 1'b1;
    ce  = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    bus.a = '0;
    bus.b = '0;
    step(3);
    check_idle_outputs("reset");
    rst = 1'b0;
    step(1);

    // Single term and its exact latency
    send(1, 1, 1, 16'sh4000, 16'sh4000);
    check("lat_edge0", 64'(bus.y_valid), 64'd0);
    step(1);
    check("lat_edge1", 64'(bus.y_valid), 64'd0);
    step(1);
    check("lat_edge2", 64'(bus.y_valid), 64'd0);
    step(1);
    check("lat_edge3", 64'(bus.y_valid), 64'd1);
    check("single_y", 64'(unsigned'(bus.y)), 64'h1000_0000);
    step(1);
    check("lat_edge4", 64'(bus.y_valid), 64'd0);
    drain();

    // Four terms, then a second sum back-to-back
    a4[0] = 16'sd1000; a4[1] = -16'sd2000; a4[2] = 16'sd3000; a4[3] = -16'sd4000;
    for (int i = 0; i < 4; i++) send(1, i == 0, i == 3, a4[i], 16'sd3);
    for (int i = 0; i < 4; i++) send(1, i == 0, i == 3, 16'(i * 7 - 5), -16'sd11);
    drain();

    // Back-to-back single-term sums give unbroken y_valid
    send(1, 1, 1, 16'sd5, 16'sd6);
    send(1, 1, 1, -16'sd5, 16'sd6);
    send(1, 1, 1, 16'sd100, -16'sd100);
    step(1);
    check("b2b_0", 64'(bus.y_valid), 64'd1);
    step(1);
    check("b2b_1", 64'(bus.y_valid), 64'd1);
    step(1);
    check("b2b_2", 64'(bus.y_valid), 64'd1);
    step(1);
    check("b2b_end", 64'(bus.y_valid), 64'd0);
    drain();

    // Saturation, both signs
    for (int i = 0; i < 8; i++) send(1, i == 0, i == 7, -16'sd32768, -16'sd32768);
    drain();
    for (int i = 0; i < 8; i++) send(1, i == 0, i == 7, -16'sd32768, 16'sd32767);
    drain();

    // Framing errors: restart mid-sum, orphan beat, too many terms
    send(1, 1, 0, 16'sd10, 16'sd10);
    send(1, 0, 0, 16'sd1, 16'sd1);
    send(1, 1, 0, 16'sd2, 16'sd2);
    send(1, 0, 1, 16'sd3, 16'sd3);
    drain();
    send(1, 0, 0, 16'sd5, 16'sd5);
    drain();
    for (int i = 0; i < 9; i++) send(1, i == 0, i == 8, 16'(1000 + i), 16'sd77);
    drain();

    // CE stall mid-sum and while the result is presented
    send(1, 1, 0, 16'sd1234, -16'sd321);
    ce = 1'b0;
    step(5);
    check("stall_busy", 64'(bus.busy), 64'd1);
    ce = 1'b1;
    send(1, 0, 1, 16'sd4321, 16'sd123);
    step(3);
    check("stall_pre_valid", 64'(bus.y_valid), 64'd1);
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_hold_valid", 64'(bus.y_valid), 64'd1);
      check("stall_hold_y", 64'(unsigned'(bus.y)), 64'(32'(1234 * -321 + 4321 * 123)));
      step(1);
    end
    ce = 1'b1;
    step(1);
    check("stall_release", 64'(bus.y_valid), 64'd0);
    drain();

    // Reset in the middle of a sum
    send(1, 1, 0, 16'sd50, 16'sd50);
    send(1, 0, 0, 16'sd60, 16'sd60);
    rst = 1'b1;
    step(1);
    check_idle_outputs("midreset");
    exp_q.delete();
    terms.delete();
    open_sum = 1'b0;
    rst = 1'b0;
    send(1, 1, 1, 16'sd2, -16'sd3);
    step(3);
    check("post_reset_y", 64'(unsigned'(bus.y)), 64'hFFFF_FFFA);
    drain();

    // Randomized framing, data, gaps and stalls
    for (int s = 0; s < 150; s++) begin
      int len;
      int mode;
      len  = int'($urandom_range(1, 11));
      mode = int'($urandom_range(0, 9));
      for (int i = 0; i < len; i++) begin
        bit f;
        bit l;
        logic signed [DW-1:0] ra;
        logic signed [CW-1:0] rb;
        f  = (i == 0) && (mode != 0);
        l  = (i == len - 1);
        if (mode == 1 && i > 0 && i == len / 2) f = 1'b1;
        ra = DW'($urandom);
        rb = CW'($urandom);
        if ($urandom_range(0, 7) == 0) begin
          ce = 1'b0;
          send(1, f, l, ra, rb);
          ce = 1'b1;
        end
        send(1, f, l, ra, rb);
        if ($urandom_range(0, 5) == 0) step(int'($urandom_range(1, 2)));
      end
    end
    drain();
    check("final_busy", 64'(bus.busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
